serdes_tx_scheduler: RTL
========================

SERDES_TX_SCHEDULER -- requirements
Module: serdes_tx_scheduler

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 11: clock cycles per 10-bit symbol slot handed to the serializer.
REQ-002 SHALL have parameter SYNC_SYMS, default 4: number of comma symbols sent after enable before user traffic.
REQ-003 SHALL have parameter IDLE_SYM, default 10'h17C: K28.5 (RD-) fill symbol, bit 0 transmitted first.
REQ-004 Ports (clock and reset first):
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  link transmit enable.
REQ-008 data_req  input  1  data requester has a symbol pending.
REQ-009 data_sym  input  10  data symbol, held stable while data_req is high.
REQ-010 ctrl_req  input  1  control requester has a symbol pending.
REQ-011 ctrl_sym  input  10  control symbol, held stable while ctrl_req is high.
REQ-012 data_gnt  output  1  one-cycle pulse; data_sym accepted this cycle.
REQ-013 ctrl_gnt  output  1  one-cycle pulse; ctrl_sym accepted this cycle.
REQ-014 ser_data  output  10  symbol presented to the serializer.
REQ-015 ser_valid  output  1  serializer shift enable.
REQ-016 slot_start  output  1  pulse on the first cycle of each slot.
REQ-017 link_up  output  1  high in RUN state.

Function
REQ-018 States: DISABLED, SYNC, RUN, encoded in 2 bits.
REQ-019 Slot counter: counts 0..SLOT_CYCLES-1 while ser_valid is high, wraps to 0, and is held at 0 in DISABLED.
REQ-020 Boundary cycle is defined as slot counter == SLOT_CYCLES-1; all symbol selection and state changes out of SYNC or RUN occur only on boundary cycles.
REQ-021 DISABLED -> SYNC on the first cycle enable is high; ser_data=IDLE_SYM, ser_valid=1 and slot_start=1 on the following cycle.
REQ-022 SYNC: sends IDLE_SYM for exactly SYNC_SYMS slots, then enters RUN on the last boundary; grants are never issued in SYNC.
REQ-023 RUN, boundary cycle, neither request high: next slot carries IDLE_SYM and no grant is issued.
REQ-024 RUN, boundary cycle, exactly one request high: that requester's gnt pulses this cycle, and its symbol is registered into ser_data at slot counter 0 of the next slot.
REQ-025 RUN, boundary cycle, both requests high: round-robin arbitration; the requester not granted last wins; the last-grant pointer resets to "data" so ctrl wins the first tie.
REQ-026 At most one gnt SHALL be high in any cycle; gnt SHALL never be high on a non-boundary cycle or while its req is low.
REQ-027 ser_data SHALL change only at slot counter 0 and be stable for the whole slot.
REQ-028 Latency from gnt to the symbol on ser_data is 1 cycle; a requester may drop req or change its symbol on the cycle after gnt.
REQ-029 enable low in SYNC or RUN: the current slot completes; on its boundary no grant is issued, the state becomes DISABLED, and ser_valid=0 from the next cycle.
REQ-030 enable re-asserted on the same boundary where it would disable: remains in the current state with no SYNC restart.
REQ-031 Requests arriving on a non-boundary cycle are held by the requester and sampled at the next boundary; the block does not latch requests.
REQ-032 slot_start=1 exactly when slot counter==0 and ser_valid==1.

Reset
REQ-033 reset high asynchronously forces: state DISABLED, slot counter 0, ser_data=IDLE_SYM, ser_valid=0, data_gnt=0, ctrl_gnt=0, slot_start=0, link_up=0, last-grant pointer = data.
REQ-034 reset asserted mid-slot SHALL abort the slot immediately; after release with enable high, the block SHALL restart with a full SYNC sequence.

Verification
REQ-035 Bring-up: enable=1, no requests -> ser_valid from cycle 1; 4 slots of 10'h17C (44 cycles), then link_up=1 and 10'h17C continues.
REQ-036 Single data: RUN, data_req=1 with data_sym=10'h2A5 -> data_gnt pulses on one boundary; ser_data=10'h2A5 next cycle, held 11 cycles; then 10'h17C if req dropped.
REQ-037 Contention: both reqs held high in RUN (ctrl=10'h0F3, data=10'h30C) -> grants alternate ctrl, data, ctrl, data on successive boundaries, never both in one cycle.
REQ-038 Disable mid-slot: enable=0 at slot counter 3 -> slot finishes at counter 10; no gnt on that boundary; ser_valid=0 next cycle; requests are ignored afterwards.
REQ-039 Reset mid-traffic: reset at slot counter 5 with data_req high -> all outputs go to reset values asynchronously; after release, 4 sync slots precede the next data_gnt.
REQ-040 Checker: gnt only on boundaries, ser_data stable within a slot, and one slot_start every SLOT_CYCLES cycles while ser_valid is high.

Source files
------------

// File: rtl/serdes_tx_scheduler.sv
// Serializer transmit slot scheduler: brings the link up with a run of comma
// symbols, then fills each fixed-length symbol slot with either an idle symbol
// or a granted data/control symbol chosen by round-robin on slot boundaries.
module serdes_tx_scheduler #(
    parameter int unsigned SLOT_CYCLES = 11,
    parameter int unsigned SYNC_SYMS   = 4,
    parameter logic [9:0]  IDLE_SYM    = 10'h17C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       data_req,
    input  logic [9:0] data_sym,
    input  logic       ctrl_req,
    input  logic [9:0] ctrl_sym,
    output logic       data_gnt,
    output logic       ctrl_gnt,
    output logic [9:0] ser_data,
    output logic       ser_valid,
    output logic       slot_start,
    output logic       link_up
);

    localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned SW = (SYNC_SYMS > 1) ? $clog2(SYNC_SYMS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_SYMS - 1);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sync_q, sync_d;
    logic [9:0]    sym_q, sym_d;
    logic          valid_q, valid_d;
    logic          last_ctrl_q, last_ctrl_d;   // 1 = control held the last grant

    logic boundary;
    logic pick_ctrl;
    logic pick_data;

    assign boundary  = valid_q && (cnt_q == CNT_LAST);
    // On a tie the requester that did not win last time is chosen.
    assign pick_ctrl = ctrl_req && (!data_req || !last_ctrl_q);
    assign pick_data = data_req && !pick_ctrl;

    // Next-state, slot counter, symbol selection and grant pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sync_d      = sync_q;
        sym_d       = sym_q;
        valid_d     = valid_q;
        last_ctrl_d = last_ctrl_q;
        data_gnt    = 1'b0;
        ctrl_gnt    = 1'b0;

        if (valid_q) begin
            cnt_d = boundary ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_DISABLED: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ST_SYNC;
                    valid_d = 1'b1;
                    sync_d  = '0;
                    sym_d   = IDLE_SYM;
                end
            end
            ST_SYNC: begin
                if (boundary) begin
                    sym_d = IDLE_SYM;
                    if (!enable) begin
                        state_d = ST_DISABLED;
                        valid_d = 1'b0;
                    end else if (sync_q == SYNC_LAST) begin
                        state_d = ST_RUN;
                        sync_d  = '0;
                    end else begin
                        sync_d = sync_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    if (!enable) begin
                        state_d = ST_DISABLED;
                        valid_d = 1'b0;
                        sym_d   = IDLE_SYM;
                    end else if (pick_ctrl) begin
                        ctrl_gnt    = 1'b1;
                        sym_d       = ctrl_sym;
                        last_ctrl_d = 1'b1;
                    end else if (pick_data) begin
                        data_gnt    = 1'b1;
                        sym_d       = data_sym;
                        last_ctrl_d = 1'b0;
                    end else begin
                        sym_d = IDLE_SYM;
                    end
                end
            end
            default: begin
                state_d = ST_DISABLED;
                valid_d = 1'b0;
                cnt_d   = '0;
                sym_d   = IDLE_SYM;
            end
        endcase
    end

    // State register with asynchronous reset to the idle, link-down condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_DISABLED;
            cnt_q       <= '0;
            sync_q      <= '0;
            sym_q       <= IDLE_SYM;
            valid_q     <= 1'b0;
            last_ctrl_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            sym_q       <= sym_d;
            valid_q     <= valid_d;
            last_ctrl_q <= last_ctrl_d;
        end
    end

    assign ser_data   = sym_q;
    assign ser_valid  = valid_q;
    assign slot_start = valid_q && (cnt_q == '0);
    assign link_up    = (state_q == ST_RUN);

endmodule
